// File: rtl/calc_pkg.sv
// Shared types and constants for the hex calculator key sequencer.
// Holds the FSM encoding, opcode values and timing limits.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_V1,
    OP_WAIT,
    ENTER_V2,
    EXEC,
    SHOW,
    ERR
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  localparam int TIMEOUT_CYCLES = 32;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [15:0] ERR_DISPLAY = 16'hEEEE;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_DIGITS = 3'd4;

endpackage

// File: rtl/calc_operand_entry.sv
// One 16-bit operand register with 0-4 digit shift-in entry.
// Extra digits past the fourth are silently dropped.
module calc_operand_entry
  import calc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_set,
  input  logic        i_load,
  input  logic        i_shift,
  input  logic [3:0]  i_digit,
  input  logic [15:0] i_value,
  output logic [15:0] o_value,
  output logic [15:0] o_value_nxt
);

  logic [15:0]      r_value;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      w_value_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_value_nxt = r_value;
    w_count_nxt = r_count;
    if (i_clr) begin
      w_value_nxt = '0;
      w_count_nxt = '0;
    end else if (i_set) begin
      // a loaded result counts as a full operand
      w_value_nxt = i_value;
      w_count_nxt = MAX_DIGITS;
    end else if (i_load) begin
      w_value_nxt = {12'h000, i_digit};
      w_count_nxt = CNT_W'(1);
    end else if (i_shift && (r_count < MAX_DIGITS)) begin
      w_value_nxt = {r_value[11:0], i_digit};
      w_count_nxt = r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= '0;
      r_count <= '0;
    end else begin
      r_value <= w_value_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_value     = r_value;
  assign o_value_nxt = w_value_nxt;

endmodule

// File: rtl/calc_sequencer.sv
// Key-entry sequencer for a 4-digit hex calculator.
// Collects operands, launches the arithmetic unit and drives the display.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        newhex,
  input  logic [3:0]  hexcode,
  input  logic        newop,
  input  logic [1:0]  opcode,
  input  logic        eq,
  input  logic        arith_done,
  input  logic [15:0] arith_ans,
  input  logic        arith_ovf,
  output logic [15:0] V1,
  output logic [15:0] V2,
  output logic [1:0]  op_reg,
  output logic        arith_start,
  output logic [15:0] display,
  output logic        busy,
  output logic        error
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [1:0]       w_op_nxt;
  logic [1:0]       r_pend;
  logic [1:0]       w_pend_nxt;
  logic             r_chain;
  logic             w_chain_nxt;
  logic [15:0]      r_result;
  logic [15:0]      w_result_nxt;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             r_start;
  logic             r_busy;
  logic             r_error;
  logic [15:0]      r_display;
  logic [15:0]      w_display_nxt;

  logic             w_hex;
  logic             w_op;
  logic             w_eq;

  logic             w_v1_clr;
  logic             w_v1_set;
  logic             w_v1_load;
  logic             w_v1_shift;
  logic [15:0]      w_v1_set_val;
  logic [15:0]      w_v1_nxt;
  logic             w_v2_clr;
  logic             w_v2_load;
  logic             w_v2_shift;
  logic [15:0]      w_v2_nxt;

  // eq beats newop beats newhex; losers are dropped
  assign w_eq  = eq;
  assign w_op  = newop & ~eq;
  assign w_hex = newhex & ~eq & ~newop;

  calc_operand_entry u_v1 (
    .clock       (clock),
    .reset       (reset),
    .i_clr       (w_v1_clr),
    .i_set       (w_v1_set),
    .i_load      (w_v1_load),
    .i_shift     (w_v1_shift),
    .i_digit     (hexcode),
    .i_value     (w_v1_set_val),
    .o_value     (V1),
    .o_value_nxt (w_v1_nxt)
  );

  calc_operand_entry u_v2 (
    .clock       (clock),
    .reset       (reset),
    .i_clr       (w_v2_clr),
    .i_set       (1'b0),
    .i_load      (w_v2_load),
    .i_shift     (w_v2_shift),
    .i_digit     (hexcode),
    .i_value     (16'h0000),
    .o_value     (V2),
    .o_value_nxt (w_v2_nxt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_pend_nxt   = r_pend;
    w_chain_nxt  = r_chain;
    w_result_nxt = r_result;
    w_tmo_nxt    = r_tmo;
    w_v1_clr     = 1'b0;
    w_v1_set     = 1'b0;
    w_v1_load    = 1'b0;
    w_v1_shift   = 1'b0;
    w_v1_set_val = arith_ans;
    w_v2_clr     = 1'b0;
    w_v2_load    = 1'b0;
    w_v2_shift   = 1'b0;
    unique case (r_state)
      ENTER_V1: begin
        if (w_op) begin
          w_op_nxt    = opcode;
          w_v2_clr    = 1'b1;
          w_state_nxt = OP_WAIT;
        end else if (w_hex) begin
          w_v1_shift = 1'b1;
        end
      end
      OP_WAIT: begin
        if (w_op) begin
          w_op_nxt = opcode;
        end else if (w_hex) begin
          w_v2_load   = 1'b1;
          w_state_nxt = ENTER_V2;
        end
      end
      ENTER_V2: begin
        if (w_eq) begin
          w_chain_nxt = 1'b0;
          w_state_nxt = EXEC;
        end else if (w_op) begin
          w_pend_nxt  = opcode;
          w_chain_nxt = 1'b1;
          w_state_nxt = EXEC;
        end else if (w_hex) begin
          w_v2_shift = 1'b1;
        end
      end
      EXEC: begin
        if (arith_done) begin
          if (arith_ovf) begin
            w_chain_nxt = 1'b0;
            w_state_nxt = ERR;
          end else begin
            w_result_nxt = arith_ans;
            if (r_chain) begin
              w_v1_set    = 1'b1;
              w_op_nxt    = r_pend;
              w_chain_nxt = 1'b0;
              w_state_nxt = OP_WAIT;
            end else begin
              w_state_nxt = SHOW;
            end
          end
        end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          w_chain_nxt = 1'b0;
          w_state_nxt = ERR;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      SHOW: begin
        if (w_eq) begin
          w_v1_set     = 1'b1;
          w_v1_set_val = r_result;
          w_state_nxt  = EXEC;
        end else if (w_op) begin
          w_v1_set     = 1'b1;
          w_v1_set_val = r_result;
          w_op_nxt     = opcode;
          w_v2_clr     = 1'b1;
          w_state_nxt  = OP_WAIT;
        end else if (w_hex) begin
          w_v1_load   = 1'b1;
          w_state_nxt = ENTER_V1;
        end
      end
      ERR: begin
        if (w_hex) begin
          w_v1_load   = 1'b1;
          w_v2_clr    = 1'b1;
          w_state_nxt = ENTER_V1;
        end
      end
      default: w_state_nxt = ENTER_V1;
    endcase
    if (w_state_nxt != EXEC) w_tmo_nxt = '0;
  end

  // display is registered from next-cycle values so it tracks state
  always_comb begin
    w_display_nxt = r_display;
    unique case (w_state_nxt)
      ENTER_V1: w_display_nxt = w_v1_nxt;
      OP_WAIT:  w_display_nxt = w_v1_nxt;
      ENTER_V2: w_display_nxt = w_v2_nxt;
      EXEC:     w_display_nxt = r_display;
      SHOW:     w_display_nxt = w_result_nxt;
      ERR:      w_display_nxt = ERR_DISPLAY;
      default:  w_display_nxt = r_display;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ENTER_V1;
      r_op      <= '0;
      r_pend    <= '0;
      r_chain   <= 1'b0;
      r_result  <= '0;
      r_tmo     <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
      r_display <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_pend    <= w_pend_nxt;
      r_chain   <= w_chain_nxt;
      r_result  <= w_result_nxt;
      r_tmo     <= w_tmo_nxt;
      r_start   <= (w_state_nxt == EXEC) && (r_state != EXEC);
      r_busy    <= (w_state_nxt == EXEC);
      r_error   <= (w_state_nxt == ERR);
      r_display <= w_display_nxt;
    end
  end

  assign op_reg      = r_op;
  assign arith_start = r_start;
  assign busy        = r_busy;
  assign error       = r_error;
  assign display     = r_display;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboarded random/directed bench for calc_sequencer.
// Models the calculator at key level and plays the arithmetic unit.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        newhex = 1'b0;
  logic [3:0]  hexcode = 4'h0;
  logic        newop = 1'b0;
  logic [1:0]  opcode = 2'd0;
  logic        eq = 1'b0;
  logic        arith_done = 1'b0;
  logic [15:0] arith_ans = 16'h0;
  logic        arith_ovf = 1'b0;
  logic [15:0] V1, V2, display;
  logic [1:0]  op_reg;
  logic        arith_start, busy, error;

  calc_sequencer dut (
    .clock(clock), .reset(reset), .newhex(newhex), .hexcode(hexcode),
    .newop(newop), .opcode(opcode), .eq(eq), .arith_done(arith_done),
    .arith_ans(arith_ans), .arith_ovf(arith_ovf), .V1(V1), .V2(V2),
    .op_reg(op_reg), .arith_start(arith_start), .display(display),
    .busy(busy), .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [15:0] v1;
    logic [15:0] v2;
    logic [1:0]  op;
  } start_t;
  start_t exp_q[$];

  localparam int M_V1 = 0, M_OPW = 1, M_V2 = 2;
  localparam int M_EXEC = 3, M_SHOW = 4, M_ERR = 5;

  int          mode;
  int          n1, n2;
  logic [15:0] mv1, mv2, mres, mdisp;
  logic [1:0]  mop, mpend;
  bit          mchain;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] alu(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic [1:0] op);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return p[15:0];
      OP_AND:  return a & b;
      default: return 16'h0;
    endcase
  endfunction

  function automatic void upd_disp();
    case (mode)
      M_V1, M_OPW: mdisp = mv1;
      M_V2:        mdisp = mv2;
      M_SHOW:      mdisp = mres;
      M_ERR:       mdisp = 16'hEEEE;
      default:     mdisp = mdisp;
    endcase
  endfunction

  function automatic void m_reset();
    mode = M_V1; n1 = 0; n2 = 0;
    mv1 = 0; mv2 = 0; mres = 0; mdisp = 0;
    mop = 0; mpend = 0; mchain = 0;
  endfunction

  function automatic void m_start();
    start_t s;
    s.v1 = mv1; s.v2 = mv2; s.op = mop;
    exp_q.push_back(s);
    mode = M_EXEC;
  endfunction

  function automatic void m_hex(input logic [3:0] d);
    case (mode)
      M_V1: if (n1 < 4) begin mv1 = {mv1[11:0], d}; n1++; end
      M_OPW: begin mv2 = 16'(d); n2 = 1; mode = M_V2; end
      M_V2: if (n2 < 4) begin mv2 = {mv2[11:0], d}; n2++; end
      M_SHOW: begin mv1 = 16'(d); n1 = 1; mode = M_V1; end
      M_ERR: begin
        mv1 = 16'(d); n1 = 1; mv2 = 0; n2 = 0; mode = M_V1;
      end
      default: ;
    endcase
    upd_disp();
  endfunction

  function automatic void m_op(input logic [1:0] o);
    case (mode)
      M_V1: begin mop = o; mv2 = 0; n2 = 0; mode = M_OPW; end
      M_OPW: mop = o;
      M_V2: begin mpend = o; mchain = 1; m_start(); end
      M_SHOW: begin
        mv1 = mres; n1 = 4; mop = o; mv2 = 0; n2 = 0; mode = M_OPW;
      end
      default: ;
    endcase
    upd_disp();
  endfunction

  function automatic void m_eq();
    case (mode)
      M_V2: begin mchain = 0; m_start(); end
      M_SHOW: begin mv1 = mres; n1 = 4; m_start(); end
      default: ;
    endcase
    upd_disp();
  endfunction

  function automatic void m_done(input bit ovf, input logic [15:0] ans);
    if (ovf) begin
      mode = M_ERR; mchain = 0;
    end else begin
      mres = ans;
      if (mchain) begin
        mv1 = ans; n1 = 4; mop = mpend; mchain = 0; mode = M_OPW;
      end else begin
        mode = M_SHOW;
      end
    end
    upd_disp();
  endfunction

  // kind: 0 hex, 1 op, 2 eq; model first so expectations lead the DUT
  task automatic press(input int kind, input logic [3:0] val);
    case (kind)
      0: m_hex(val);
      1: m_op(val[1:0]);
      default: m_eq();
    endcase
    @(negedge clock);
    newhex = (kind == 0); newop = (kind == 1); eq = (kind == 2);
    hexcode = val; opcode = val[1:0];
    @(negedge clock);
    newhex = 0; newop = 0; eq = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".display"}, display, mdisp);
    chk({tag, ".error"}, error, mode == M_ERR);
    chk({tag, ".busy"}, busy, mode == M_EXEC);
    chk({tag, ".V1"}, V1, mv1);
    chk({tag, ".V2"}, V2, mv2);
    chk({tag, ".op_reg"}, op_reg, mop);
    if (mode != M_EXEC) chk({tag, ".start_idle"}, arith_start, 0);
  endtask

  task automatic run_exec(input int delay, input bit ovf, input bit noise);
    logic [15:0] ans;
    for (int i = 0; i < delay; i++) begin
      newhex = noise && (i == 1); hexcode = 4'h9;
      eq = noise && (i == 2);
      @(negedge clock);
    end
    newhex = 0; eq = 0;
    check_all("exec");
    ans = alu(mv1, mv2, mop);
    arith_done = 1; arith_ovf = ovf; arith_ans = ans;
    @(negedge clock);
    arith_done = 0; arith_ovf = 0;
    m_done(ovf, ans);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    m_reset();
  endtask

  // monitor: every start pulse must match the oldest queued operand set
  initial begin
    logic prev;
    start_t e;
    prev = 0;
    forever begin
      @(negedge clock);
      if (arith_start) begin
        chk("start.single_cycle", prev, 0);
        chk("start.expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("start.V1", V1, e.v1);
          chk("start.V2", V2, e.v2);
          chk("start.op", op_reg, e.op);
        end
      end
      prev = arith_start;
    end
  end

  initial begin
    int k;
    m_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    reset = 0;

    press(0, 4'h1); press(0, 4'h2); press(1, 4'h0); press(0, 4'h3);
    press(2, 4'h0);
    check_all("add_trig");
    run_exec(3, 0, 0);
    check_all("add_show");
    chk("add.display", display, 16'h0015);

    do_reset();
    for (int i = 1; i <= 5; i++) press(0, 4'(i));
    check_all("five_digits");
    chk("five.V1", V1, 16'h1234);

    do_reset();
    press(0, 4'h5); press(1, 4'h2); press(0, 4'h2); press(1, 4'h0);
    run_exec(4, 0, 0);
    check_all("chain");
    chk("chain.V1", V1, 16'h000A);
    press(0, 4'h1); press(2, 4'h0);
    run_exec(2, 0, 0);
    check_all("chain2");

    press(1, 4'h0); press(0, 4'h1); press(2, 4'h0);
    run_exec(5, 1, 0);
    check_all("ovf");
    chk("ovf.display", display, 16'hEEEE);
    press(0, 4'h7);
    check_all("ovf_recover");

    press(1, 4'h1); press(0, 4'h1); press(2, 4'h0);
    for (int i = 0; i < 40; i++) begin
      newhex = (i == 1); hexcode = 4'hC; eq = (i == 3);
      @(negedge clock);
      if (i == 20) check_all("tmo_busy");
    end
    newhex = 0; eq = 0;
    m_done(1, 16'h0);
    check_all("timeout");

    press(0, 4'h4); press(1, 4'h3); press(0, 4'h6); press(2, 4'h0);
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    m_reset();
    check_all("mid_reset");
    arith_done = 1; arith_ans = 16'h5555;
    @(negedge clock);
    arith_done = 0;
    @(negedge clock);
    check_all("stray_done");

    do_reset();
    repeat (250) begin
      k = $urandom_range(0, 9);
      press(k < 6 ? 0 : (k < 8 ? 1 : 2), 4'($urandom_range(0, 15)));
      check_all("rnd_key");
      if (mode == M_EXEC) begin
        run_exec($urandom_range(1, 8), $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)));
        check_all("rnd_done");
      end
    end

    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
